// File: rtl/lnrv_exu_wbck_arb.sv
// lnrv_exu_wbck_arb: arbitrates ALU/MDV/LSU writebacks into one registered GPR write entry
module lnrv_exu_wbck_arb #(
    parameter bit RR_EN = 1'b1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        alu_wbck_vld,
    output logic        alu_wbck_rdy,
    input  logic [31:0] alu_wbck_wdata,
    input  logic [4:0]  alu_wbck_rd_idx,
    input  logic        mdv_wbck_vld,
    output logic        mdv_wbck_rdy,
    input  logic [31:0] mdv_wbck_wdata,
    input  logic [4:0]  mdv_wbck_rd_idx,
    input  logic        lsu_wbck_vld,
    output logic        lsu_wbck_rdy,
    input  logic [31:0] lsu_wbck_wdata,
    input  logic [4:0]  lsu_wbck_rd_idx,
    output logic        gpr_wbck_vld,
    input  logic        gpr_wbck_rdy,
    output logic [31:0] gpr_wbck_wdata,
    output logic [4:0]  gpr_wbck_rd_idx,
    output logic [1:0]  gpr_wbck_src
);
    logic        out_vld, load_en, any, ld;
    logic [1:0]  last_grant, start, rr_sel, fp_sel, sel;
    logic [2:0]  v, r, k_s;
    logic [31:0] wd;
    logic [4:0]  rd;

    assign v       = {lsu_wbck_vld, mdv_wbck_vld, alu_wbck_vld};
    assign load_en = !out_vld | gpr_wbck_rdy;

    // r is v rotated so r[0] is the requester right after last_grant
    always_comb begin
        start  = (last_grant == 2'd0) ? 2'd1 : (last_grant == 2'd1) ? 2'd2 : 2'd0;
        r      = (start == 2'd0) ? v : (start == 2'd1) ? {v[0], v[2], v[1]} : {v[1], v[0], v[2]};
        k_s    = {1'b0, start} + (r[0] ? 3'd0 : r[1] ? 3'd1 : 3'd2);
        rr_sel = (k_s >= 3'd3) ? k_s[1:0] + 2'd1 : k_s[1:0];
        fp_sel = v[2] ? 2'd2 : v[1] ? 2'd1 : 2'd0;
        sel    = RR_EN ? rr_sel : fp_sel;
        any    = (|v) & load_en & reset_n;
        wd     = (sel == 2'd2) ? lsu_wbck_wdata : (sel == 2'd1) ? mdv_wbck_wdata : alu_wbck_wdata;
        rd     = (sel == 2'd2) ? lsu_wbck_rd_idx : (sel == 2'd1) ? mdv_wbck_rd_idx : alu_wbck_rd_idx;
        ld     = any & (rd != 5'd0);
    end

    assign alu_wbck_rdy = any & (sel == 2'd0);
    assign mdv_wbck_rdy = any & (sel == 2'd1);
    assign lsu_wbck_rdy = any & (sel == 2'd2);
    assign gpr_wbck_vld = out_vld;

    // writes to x0 are consumed without occupying the entry
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            out_vld         <= 1'b0;
            gpr_wbck_wdata  <= 32'd0;
            gpr_wbck_rd_idx <= 5'd0;
            gpr_wbck_src    <= 2'd0;
            last_grant      <= 2'd2;
        end else begin
            out_vld <= ld | (out_vld & !gpr_wbck_rdy);
            if (any && RR_EN) last_grant <= sel;
            if (ld) begin
                gpr_wbck_wdata  <= wd;
                gpr_wbck_rd_idx <= rd;
                gpr_wbck_src    <= sel;
            end
        end
    end
endmodule

// File: tb/tb_lnrv_exu_wbck_arb.sv
// tb_lnrv_exu_wbck_arb: directed checks of round-robin and fixed-priority writeback arbitration
module tb_lnrv_exu_wbck_arb;
    logic        clk, reset_n, gpr_rdy;
    logic        alu_v, mdv_v, lsu_v;
    logic [31:0] alu_d, mdv_d, lsu_d;
    logic [4:0]  alu_r, mdv_r, lsu_r;
    logic        a_rdy, m_rdy, l_rdy, g_vld;
    logic [31:0] g_wd;
    logic [4:0]  g_rd;
    logic [1:0]  g_src;
    logic        fa_rdy, fm_rdy, fl_rdy, fg_vld;
    logic [31:0] fg_wd;
    logic [4:0]  fg_rd;
    logic [1:0]  fg_src;
    logic [2:0]  rdy, frdy;
    int          n_cmp = 0, n_bad = 0;

    assign rdy  = {l_rdy, m_rdy, a_rdy};
    assign frdy = {fl_rdy, fm_rdy, fa_rdy};

    lnrv_exu_wbck_arb #(.RR_EN(1'b1)) u_rr (
        .clk(clk), .reset_n(reset_n),
        .alu_wbck_vld(alu_v), .alu_wbck_rdy(a_rdy), .alu_wbck_wdata(alu_d), .alu_wbck_rd_idx(alu_r),
        .mdv_wbck_vld(mdv_v), .mdv_wbck_rdy(m_rdy), .mdv_wbck_wdata(mdv_d), .mdv_wbck_rd_idx(mdv_r),
        .lsu_wbck_vld(lsu_v), .lsu_wbck_rdy(l_rdy), .lsu_wbck_wdata(lsu_d), .lsu_wbck_rd_idx(lsu_r),
        .gpr_wbck_vld(g_vld), .gpr_wbck_rdy(gpr_rdy), .gpr_wbck_wdata(g_wd),
        .gpr_wbck_rd_idx(g_rd), .gpr_wbck_src(g_src)
    );

    lnrv_exu_wbck_arb #(.RR_EN(1'b0)) u_fp (
        .clk(clk), .reset_n(reset_n),
        .alu_wbck_vld(alu_v), .alu_wbck_rdy(fa_rdy), .alu_wbck_wdata(alu_d), .alu_wbck_rd_idx(alu_r),
        .mdv_wbck_vld(mdv_v), .mdv_wbck_rdy(fm_rdy), .mdv_wbck_wdata(mdv_d), .mdv_wbck_rd_idx(mdv_r),
        .lsu_wbck_vld(lsu_v), .lsu_wbck_rdy(fl_rdy), .lsu_wbck_wdata(lsu_d), .lsu_wbck_rd_idx(lsu_r),
        .gpr_wbck_vld(fg_vld), .gpr_wbck_rdy(gpr_rdy), .gpr_wbck_wdata(fg_wd),
        .gpr_wbck_rd_idx(fg_rd), .gpr_wbck_src(fg_src)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // a stalled requester must keep its payload stable
    a_alu_hold: assert property (@(posedge clk) disable iff (!reset_n)
        alu_v && !a_rdy |=> !alu_v || ($stable(alu_d) && $stable(alu_r)));
    a_mdv_hold: assert property (@(posedge clk) disable iff (!reset_n)
        mdv_v && !m_rdy |=> !mdv_v || ($stable(mdv_d) && $stable(mdv_r)));
    a_lsu_hold: assert property (@(posedge clk) disable iff (!reset_n)
        lsu_v && !l_rdy |=> !lsu_v || ($stable(lsu_d) && $stable(lsu_r)));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        alu_v = 1'b0;
        mdv_v = 1'b0;
        lsu_v = 1'b0;
    endtask

    task automatic do_reset;
        idle();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
    endtask

    logic [2:0] exp_rdy [4] = '{3'b001, 3'b010, 3'b100, 3'b001};
    logic [1:0] exp_src [4] = '{2'd0, 2'd1, 2'd2, 2'd0};

    initial begin
        reset_n = 1'b0; gpr_rdy = 1'b1; idle();
        alu_d = 0; alu_r = 0; mdv_d = 0; mdv_r = 0; lsu_d = 0; lsu_r = 0;
        tick();
        alu_v = 1'b1; alu_r = 5'd9;
        tick();
        chk("rst_rdy", rdy, 3'b000);
        chk("rst_frdy", frdy, 3'b000);
        chk("rst_vld", g_vld, 0);
        chk("rst_wd", g_wd, 0);
        chk("rst_rd", g_rd, 0);
        chk("rst_src", g_src, 0);
        alu_v = 1'b0;
        reset_n = 1'b1;

        // single ALU write, latency 1
        alu_v = 1'b1; alu_d = 32'h11; alu_r = 5'd3; #1;
        chk("alu_rdy", rdy, 3'b001);
        tick();
        alu_v = 1'b0; #1;
        chk("alu_vld", g_vld, 1);
        chk("alu_wd", g_wd, 32'h11);
        chk("alu_rd", g_rd, 3);
        chk("alu_src", g_src, 0);
        tick();
        chk("drain_vld", g_vld, 0);

        // round robin rotation from reset
        do_reset();
        alu_d = 32'hA0; alu_r = 5'd1; mdv_d = 32'hB0; mdv_r = 5'd2; lsu_d = 32'hC0; lsu_r = 5'd4;
        alu_v = 1'b1; mdv_v = 1'b1; lsu_v = 1'b1; #1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("rr_rdy%0d", i), rdy, exp_rdy[i]);
            if (i > 0) chk($sformatf("rr_src%0d", i - 1), g_src, exp_src[i - 1]);
            tick();
        end
        chk("rr_src3", g_src, 0);
        chk("rr_wd3", g_wd, 32'hA0);
        idle(); #1;
        chk("rr_idle_rdy", rdy, 3'b000);
        tick();

        // fixed priority instance
        alu_v = 1'b1; mdv_v = 1'b1; lsu_v = 1'b1; #1;
        chk("fp_rdy0", frdy, 3'b100);
        tick();
        chk("fp_rdy1", frdy, 3'b100);
        chk("fp_src0", fg_src, 2);
        tick();
        lsu_v = 1'b0; #1;
        chk("fp_rdy2", frdy, 3'b010);
        tick();
        mdv_v = 1'b0; #1;
        chk("fp_rdy3", frdy, 3'b001);
        chk("fp_src2", fg_src, 1);
        tick();
        alu_v = 1'b0; #1;
        chk("fp_src3", fg_src, 0);
        chk("fp_wd3", fg_wd, 32'hA0);
        tick();

        // backpressure: entry held, MDV waits, then drain + accept together
        gpr_rdy = 1'b0;
        alu_v = 1'b1; alu_d = 32'h22; alu_r = 5'd5; #1;
        chk("bp_alu_rdy", rdy, 3'b001);
        tick();
        alu_v = 1'b0; mdv_v = 1'b1; mdv_d = 32'h33; mdv_r = 5'd6; #1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("bp_rdy%0d", i), rdy, 3'b000);
            chk($sformatf("bp_vld%0d", i), g_vld, 1);
            chk($sformatf("bp_wd%0d", i), g_wd, 32'h22);
            chk($sformatf("bp_rd%0d", i), g_rd, 5);
            tick();
        end
        gpr_rdy = 1'b1; #1;
        chk("bp_mdv_rdy", rdy, 3'b010);
        tick();
        mdv_v = 1'b0; #1;
        chk("bp_mdv_vld", g_vld, 1);
        chk("bp_mdv_wd", g_wd, 32'h33);
        chk("bp_mdv_rd", g_rd, 6);
        chk("bp_mdv_src", g_src, 1);
        tick();

        // write to x0 is consumed but never presented
        lsu_v = 1'b1; lsu_d = 32'h44; lsu_r = 5'd0; #1;
        chk("x0_rdy", rdy, 3'b100);
        tick();
        lsu_v = 1'b0; #1;
        chk("x0_vld", g_vld, 0);
        alu_v = 1'b1; mdv_v = 1'b1; lsu_v = 1'b1; #1;
        chk("x0_next_rr", rdy, 3'b001);
        idle(); #1;
        tick();

        // reset drops a pending entry and restores ALU-first priority
        gpr_rdy = 1'b0;
        alu_v = 1'b1; alu_d = 32'h55; alu_r = 5'd7; #1;
        chk("mr_alu_rdy", rdy, 3'b001);
        tick();
        chk("mr_held", g_vld, 1);
        reset_n = 1'b0; mdv_v = 1'b1; lsu_v = 1'b1; #1;
        chk("mr_rdy_rst", rdy, 3'b000);
        chk("mr_frdy_rst", frdy, 3'b000);
        tick();
        reset_n = 1'b1; #1;
        chk("mr_vld", g_vld, 0);
        chk("mr_first", rdy, 3'b001);
        tick();
        idle(); #1;
        chk("mr_out_vld", g_vld, 1);
        chk("mr_out_wd", g_wd, 32'h55);
        chk("mr_out_src", g_src, 0);
        gpr_rdy = 1'b1;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/lnrv_exu_wbck_arb.md
LNRV_EXU_WBCK_ARB -- requirements
Module: lnrv_exu_wbck_arb

Interface
REQ-001 SHALL have parameter: RR_EN, 1, 1 = round-robin arbitration; 0 = fixed priority LSU > MDV > ALU.
REQ-002 SHALL have ports, one clock, reset synchronous active-low:
  clk  in  1  clock; all state updates on rising edge.
  reset_n  in  1  synchronous active-low reset.
  alu_wbck_vld  in  1  ALU writeback request.
  alu_wbck_rdy  out  1  ALU request accepted this cycle.
  alu_wbck_wdata  in  32  ALU result.
  alu_wbck_rd_idx  in  5  ALU destination register.
  mdv_wbck_vld  in  1  MDV writeback request.
  mdv_wbck_rdy  out  1  MDV request accepted this cycle.
  mdv_wbck_wdata  in  32  MDV result.
  mdv_wbck_rd_idx  in  5  MDV destination register.
  lsu_wbck_vld  in  1  LSU writeback request.
  lsu_wbck_rdy  out  1  LSU request accepted this cycle.
  lsu_wbck_wdata  in  32  LSU load data.
  lsu_wbck_rd_idx  in  5  LSU destination register.
  gpr_wbck_vld  out  1  registered write to GPR file valid.
  gpr_wbck_rdy  in  1  GPR file accepts write.
  gpr_wbck_wdata  out  32  write data.
  gpr_wbck_rd_idx  out  5  write register index.
  gpr_wbck_src  out  2  source of held write: 0 ALU, 1 MDV, 2 LSU.

Function
REQ-003 SHALL hold one output entry (out_vld, wdata, rd_idx, src) driving gpr_wbck_* directly from registers.
REQ-004 SHALL compute load_en = !out_vld | gpr_wbck_rdy; no requester accepted when load_en = 0.
REQ-005 SHALL grant at most one requester per cycle, only among those with vld = 1, and only when load_en = 1.
REQ-006 SHALL assert x_wbck_rdy for exactly the granted requester in that cycle; rdy combinational from vld inputs, pointer and load_en.
REQ-007 RR_EN = 1: priority order SHALL start at the requester after last_grant (ALU -> MDV -> LSU -> ALU wrap-around).
REQ-008 RR_EN = 1: last_grant SHALL update only on an actual grant; unchanged on idle or stalled cycles.
REQ-009 RR_EN = 0: LSU wins over MDV, MDV over ALU; last_grant register unused.
REQ-010 On grant with rd_idx != 0: entry SHALL load at the next edge; gpr_wbck_vld = 1 one cycle after acceptance (latency 1).
REQ-011 On grant with rd_idx = 0: request SHALL be consumed (rdy = 1, pointer updated) but entry not loaded; out_vld clears if drained that same cycle.
REQ-012 No grant with load_en = 1: out_vld SHALL clear if gpr_wbck_rdy = 1, else hold.
REQ-013 While out_vld = 1 and gpr_wbck_rdy = 0: all gpr_wbck_* SHALL stay stable.
REQ-014 Drain and new grant in the same cycle SHALL be allowed; throughput 1 write/cycle when gpr_wbck_rdy = 1.
REQ-015 Ungranted requesters SHALL see rdy = 0; requesters hold vld/data until granted (requester obligation, checked by assertion).
REQ-016 No combinational path SHALL exist from x_wbck_vld to gpr_wbck_* outputs.

Reset
REQ-017 On reset_n = 0 at rising edge: out_vld = 0, gpr_wbck_wdata = 0, gpr_wbck_rd_idx = 0, gpr_wbck_src = 0, last_grant = LSU (ALU first priority after reset).
REQ-018 While reset_n = 0 all x_wbck_rdy SHALL be 0; a held entry is discarded (reset mid-operation drops pending write).

Verification
REQ-019 Reset, then ALU only, vld, wdata 0x11, rd 3, gpr_rdy = 1 -> alu_rdy = 1 same cycle; next cycle gpr_wbck_vld = 1, wdata 0x11, rd_idx 3, src 0.
REQ-020 RR_EN = 1, all three vld continuously, gpr_rdy = 1 -> grants ALU, MDV, LSU, ALU, ... one per cycle; src sequence 0,1,2,0.
REQ-021 RR_EN = 0, all three vld -> LSU granted each cycle; MDV granted only after LSU vld drops; ALU last.
REQ-022 Entry held, gpr_rdy = 0 for 3 cycles with MDV vld -> mdv_rdy = 0 and outputs stable 3 cycles; gpr_rdy = 1 -> drain and MDV accepted same cycle, MDV data out next cycle.
REQ-023 LSU vld with rd_idx 0, out empty -> lsu_rdy = 1, gpr_wbck_vld stays 0 next cycle, next RR grant goes to ALU.
REQ-024 Entry held with gpr_rdy = 0, reset_n = 0 one cycle -> gpr_wbck_vld = 0 next cycle, all rdy = 0 during reset, ALU first priority afterwards.
